// File: rtl/psc_trigger_pkg.sv
// Shared definitions for the multi-channel PSC trigger serializer:
// channel state encoding and the default frame geometry and bit patterns.
package psc_trigger_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARMED = 2'b01,
      SEND  = 2'b10
   } ch_state_t;

   localparam int DEFAULT_FRAME_BITS = 100;

   localparam logic [99:0] DEFAULT_TRIG_PATTERN = 100'hFF00FF00FF00FF00FF00FF00F;
   localparam logic [99:0] DEFAULT_IDLE_PATTERN = 100'hC0C0C0C0C0C0C0C0C0C0C0C0C;

endpackage

// File: rtl/psc_trigger_mux_if.sv
// Bundle of the EVR-side inputs and PSC-side outputs of psc_trigger_mux.
// The slave modport is the serializer, the master modport is whoever drives
// the triggers and watches the links.
// With PSC_TRIGGER_STATS_EN defined the bundle also carries sent_count.
interface psc_trigger_mux_if #(
   parameter int N_CH = 4
);

   logic [N_CH-1:0] evr_trigger;
   logic [N_CH-1:0] ch_enable;
   logic            clear_overrun;
   logic [N_CH-1:0] psc_output;
   logic            frame_start;
   logic [N_CH-1:0] trig_sent;
   logic [N_CH-1:0] overrun;

`ifdef PSC_TRIGGER_STATS_EN
   logic [N_CH*16-1:0] sent_count;

   modport master (
      output evr_trigger, ch_enable, clear_overrun,
      input  psc_output, frame_start, trig_sent, overrun, sent_count
   );

   modport slave (
      input  evr_trigger, ch_enable, clear_overrun,
      output psc_output, frame_start, trig_sent, overrun, sent_count
   );
`else
   modport master (
      output evr_trigger, ch_enable, clear_overrun,
      input  psc_output, frame_start, trig_sent, overrun
   );

   modport slave (
      input  evr_trigger, ch_enable, clear_overrun,
      output psc_output, frame_start, trig_sent, overrun
   );
`endif

endinterface

// File: rtl/psc_trigger_channel.sv
// One PSC channel: synchronizes its EVR trigger, detects rising edges,
// queues them in a saturating pending counter and decides per frame whether
// a trigger frame or an idle frame goes out. send_frame is the frame type
// for the bit being launched this cycle and is constant within a frame.
module psc_trigger_channel
   import psc_trigger_pkg::*;
#(
   parameter int PEND_W = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic evr_trigger,
   input  logic ch_enable,
   input  logic clear_overrun,
   input  logic boundary,
   output logic send_frame,
   output logic overrun
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   logic [1:0]        sync_q;
   logic              sync_d;
   logic              edge_pulse;
   logic              edge_ok;
   logic              drop;
   logic [PEND_W-1:0] pending;
   logic [PEND_W-1:0] pending_next;
   ch_state_t         state;
   ch_state_t         next_state;

   // Two-flop synchronizer followed by a registered rising-edge detector
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q     <= 2'b00;
         sync_d     <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], evr_trigger};
         sync_d     <= sync_q[1];
         edge_pulse <= sync_q[1] & ~sync_d;
      end
   end

   // Launch decision at frame boundaries, edge queuing in between
   always_comb begin
      next_state   = state;
      pending_next = pending;
      drop         = 1'b0;
      edge_ok      = edge_pulse & ch_enable;
      if (boundary) begin
         if (!ch_enable) begin
            next_state   = IDLE;
            pending_next = '0;
         end else if ((pending != '0) || edge_ok) begin
            next_state = SEND;
            if (!edge_ok) begin
               pending_next = pending - PEND_W'(1);
            end
         end else begin
            next_state = IDLE;
         end
      end else begin
         if (edge_ok) begin
            if (pending == PEND_MAX) begin
               drop = 1'b1;
            end else begin
               pending_next = pending + PEND_W'(1);
            end
         end
         if ((state == IDLE) && ((pending != '0) || edge_ok)) begin
            next_state = ARMED;
         end
      end
   end

   // Channel state and pending-trigger count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         pending <= '0;
      end else begin
         state   <= next_state;
         pending <= pending_next;
      end
   end

   // Sticky overrun flag; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (clear_overrun) begin
         overrun <= 1'b0;
      end
   end

   assign send_frame = (next_state == SEND);

endmodule

// File: rtl/psc_trigger_mux.sv
// Multi-channel PSC trigger serializer. One shared bit counter frames all
// links in lock-step; each channel picks trigger or idle pattern per frame
// and the selected bit is registered onto psc_output MSB first.
// Optional feature macro: PSC_TRIGGER_STATS_EN adds per-channel 16-bit
// sent_count counters on the interface.
module psc_trigger_mux
   import psc_trigger_pkg::*;
#(
   parameter int                     FRAME_BITS   = DEFAULT_FRAME_BITS,
   parameter int                     N_CH         = 4,
   parameter int                     PEND_W       = 3,
   parameter logic [FRAME_BITS-1:0]  TRIG_PATTERN = FRAME_BITS'(DEFAULT_TRIG_PATTERN),
   parameter logic [FRAME_BITS-1:0]  IDLE_PATTERN = FRAME_BITS'(DEFAULT_IDLE_PATTERN)
) (
   input  logic             clk,
   input  logic             reset,
   psc_trigger_mux_if.slave bus
);

   localparam int               CNT_W    = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] bit_idx;
   logic             boundary;
   logic             trig_bit;
   logic             idle_bit;
   logic [N_CH-1:0]  send_frame;
   logic [N_CH-1:0]  ch_overrun;
   logic [N_CH-1:0]  psc_q;
   logic [N_CH-1:0]  trig_sent_q;
   logic             frame_start_q;

   assign boundary = (cnt == '0);
   assign bit_idx  = CNT_LAST - cnt;
   assign trig_bit = TRIG_PATTERN[bit_idx];
   assign idle_bit = IDLE_PATTERN[bit_idx];

   // Shared bit counter, 0..FRAME_BITS-1; zero marks the frame boundary
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      psc_trigger_channel #(
         .PEND_W (PEND_W)
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .evr_trigger   (bus.evr_trigger[i]),
         .ch_enable     (bus.ch_enable[i]),
         .clear_overrun (bus.clear_overrun),
         .boundary      (boundary),
         .send_frame    (send_frame[i]),
         .overrun       (ch_overrun[i])
      );
   end

   // Serial output bits plus frame_start/trig_sent markers aligned with the MSB
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         psc_q         <= '0;
         trig_sent_q   <= '0;
         frame_start_q <= 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            psc_q[i] <= send_frame[i] ? trig_bit : idle_bit;
         end
         trig_sent_q   <= boundary ? send_frame : '0;
         frame_start_q <= boundary;
      end
   end

   assign bus.psc_output  = psc_q;
   assign bus.trig_sent   = trig_sent_q;
   assign bus.frame_start = frame_start_q;
   assign bus.overrun     = ch_overrun;

`ifdef PSC_TRIGGER_STATS_EN
   logic [N_CH*16-1:0] sent_count_q;

   // Per-channel count of trigger frames sent; clear_overrun also zeroes it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sent_count_q <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (bus.clear_overrun) begin
               sent_count_q[i*16 +: 16] <= 16'd0;
            end else if (trig_sent_q[i]) begin
               sent_count_q[i*16 +: 16] <= sent_count_q[i*16 +: 16] + 16'd1;
            end
         end
      end
   end

   assign bus.sent_count = sent_count_q;
`endif

endmodule
